retire_trace_fifo: RTL and testbench

//  Buffers per-cycle retirement records from the dual-issue core (update/pc/instr/reg/mem per lane)
//  and re-emits them as an in-order, one-record-per-cycle valid/ready stream for the table logger
//  and commit checker. Sits directly downstream of the core top's retire outputs. The core cannot be

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/retire_trace_fifo_if.sv | 38 +++
 rtl/retire_fifo_ram.sv | 40 ++++
 rtl/retire_trace_fifo.sv | 173 +++++++++++++++++
 tb/tb_retire_trace_fifo.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared core-side types for the retirement trace path.
//   XLEN          architectural register width
//   retire_rec_t  one retired instruction as seen by the trace consumers
//   rec_width()   packed width of retire_rec_t, used to size flat storage
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      reg_addr;
        logic [XLEN-1:0] reg_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
        logic            mem_wrt;
    } retire_rec_t;

    function automatic int unsigned rec_width();
        return $bits(retire_rec_t);
    endfunction

endpackage

// File: rtl/retire_trace_fifo_if.sv
// Retirement trace bundle: per-lane retire inputs from the core plus the
// single-record valid/ready output stream.
//   master : retire producer / stream consumer (core side + logger side)
//   slave  : the trace FIFO
//   update/pc/instr/reg_addr/reg_data/mem_addr/mem_data/mem_wrt : per-lane retire info
//   rec_valid/rec_ready/rec : head-of-FIFO record stream
interface retire_trace_fifo_if
    import riscv_pkg::*;
#(
    parameter int unsigned IssueWidth = 2
) ();

    logic [IssueWidth-1:0]           update;
    logic [IssueWidth-1:0][XLEN-1:0] pc;
    logic [IssueWidth-1:0][XLEN-1:0] instr;
    logic [IssueWidth-1:0][4:0]      reg_addr;
    logic [IssueWidth-1:0][XLEN-1:0] reg_data;
    logic [IssueWidth-1:0][XLEN-1:0] mem_addr;
    logic [IssueWidth-1:0][XLEN-1:0] mem_data;
    logic [IssueWidth-1:0]           mem_wrt;

    logic        rec_valid;
    logic        rec_ready;
    retire_rec_t rec;

    modport master (
        output update, pc, instr, reg_addr, reg_data, mem_addr, mem_data, mem_wrt,
        output rec_ready,
        input  rec_valid, rec
    );

    modport slave (
        input  update, pc, instr, reg_addr, reg_data, mem_addr, mem_data, mem_wrt,
        input  rec_ready,
        output rec_valid, rec
    );

endinterface

// File: rtl/retire_fifo_ram.sv
// Storage array for the retirement trace FIFO: Depth records, two synchronous
// write ports (lane order resolved by the caller) and one asynchronous read port.
//   clk_i              clock
//   we0_i/waddr0_i/wdata0_i   write port 0
//   we1_i/waddr1_i/wdata1_i   write port 1 (never the same address as port 0)
//   raddr_i/rdata_o    combinational read
module retire_fifo_ram
    import riscv_pkg::*;
#(
    parameter int unsigned Depth     = 16,
    parameter int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 we0_i,
    input  logic [AddrWidth-1:0] waddr0_i,
    input  retire_rec_t          wdata0_i,
    input  logic                 we1_i,
    input  logic [AddrWidth-1:0] waddr1_i,
    input  retire_rec_t          wdata1_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output retire_rec_t          rdata_o
);

    localparam int unsigned RecWidth = rec_width();

    // Data storage carries no reset; validity is tracked by the pointers.
    logic [RecWidth-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we0_i) begin
            mem_q[waddr0_i] <= wdata0_i;
        end
        if (we1_i) begin
            mem_q[waddr1_i] <= wdata1_i;
        end
    end

    assign rdata_o = retire_rec_t'(mem_q[raddr_i]);

endmodule

// File: rtl/retire_trace_fifo.sv
// Retirement trace FIFO. Compacts up to two retired instructions per cycle into
// an in-order, one-record-per-cycle valid/ready stream (first-word-fall-through).
// The core cannot stall, so a cycle whose lanes do not all fit is dropped as a
// whole and counted instead of back-pressuring.
//   clk_i       clock
//   rstn_i      synchronous active-low reset
//   bus_io      retire lanes in, record stream out (retire_trace_fifo_if.slave)
//   level_o     current occupancy
//   overflow_o  sticky drop flag
//   drop_cnt_o  saturating count of dropped records
//   clear_i     clears overflow_o and drop_cnt_o (data untouched)
//   rec_seq_o   sequence number of head record (only with RETIRE_TRACE_SEQ_EN)
// Build option: define RETIRE_TRACE_SEQ_EN to add the sequence-number port.
module retire_trace_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned IssueWidth = 2,
    parameter int unsigned Depth      = 16,
    parameter int unsigned CntWidth   = 16
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    retire_trace_fifo_if.slave         bus_io,
    output logic [$clog2(Depth):0]     level_o,
    output logic                       overflow_o,
    output logic [CntWidth-1:0]        drop_cnt_o,
    input  logic                       clear_i
`ifdef RETIRE_TRACE_SEQ_EN
    ,
    output logic [31:0]                rec_seq_o
`endif
);

    localparam int unsigned AW  = $clog2(Depth);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned FW  = LW + 1;
    localparam int unsigned CSW = CntWidth + 1;

    if (IssueWidth != 2) begin : g_bad_issue_width
        $error("retire_trace_fifo supports IssueWidth == 2 only");
    end
    if ((Depth < 4) || ((1 << AW) != Depth)) begin : g_bad_depth
        $error("retire_trace_fifo Depth must be a power of two >= 4");
    end

    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                overflow_q, overflow_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    logic [1:0]          n;
    logic [1:0]          push_n;
    logic                pop;
    logic                rec_valid;
    logic [FW-1:0]       free;
    logic                accept;
    logic                drop;
    logic [CntWidth-1:0] cnt_base;
    logic [CSW-1:0]      cnt_sum;

    logic                we0, we1;
    logic [AW-1:0]       waddr1;
    retire_rec_t         lane_rec [2];
    retire_rec_t         head_rec;

    assign rec_valid = (level_q != '0);

    always_comb begin
        n        = {1'b0, bus_io.update[0]} + {1'b0, bus_io.update[1]};
        pop      = rec_valid & bus_io.rec_ready;
        // A pop in this cycle frees a slot for this cycle's writes.
        free     = FW'(Depth) - {1'b0, level_q} + FW'(pop);
        accept   = (FW'(n) <= free);
        drop     = (n != 2'd0) && !accept;
        push_n   = accept ? n : 2'd0;

        wr_ptr_d = wr_ptr_q + AW'(push_n);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push_n) - LW'(pop);

        // A drop in the clearing cycle survives the clear.
        overflow_d = clear_i ? drop : (overflow_q | drop);
        cnt_base   = clear_i ? '0 : cnt_q;
        cnt_sum    = {1'b0, cnt_base} + CSW'(n);
        if (drop) begin
            cnt_d = cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
        end else begin
            cnt_d = cnt_base;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end

    // Lane 1 lands right after lane 0 when both retire, or in lane 0's slot
    // when it retires alone, so no bubble is left behind.
    assign we0    = rstn_i & accept & bus_io.update[0];
    assign we1    = rstn_i & accept & bus_io.update[1];
    assign waddr1 = wr_ptr_q + AW'(bus_io.update[0]);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lane_rec[i].pc       = bus_io.pc[i];
            lane_rec[i].instr    = bus_io.instr[i];
            lane_rec[i].reg_addr = bus_io.reg_addr[i];
            lane_rec[i].reg_data = bus_io.reg_data[i];
            lane_rec[i].mem_addr = bus_io.mem_addr[i];
            lane_rec[i].mem_data = bus_io.mem_data[i];
            lane_rec[i].mem_wrt  = bus_io.mem_wrt[i];
        end
    end

    retire_fifo_ram #(
        .Depth     (Depth),
        .AddrWidth (AW)
    ) u_ram (
        .clk_i    (clk_i),
        .we0_i    (we0),
        .waddr0_i (wr_ptr_q),
        .wdata0_i (lane_rec[0]),
        .we1_i    (we1),
        .waddr1_i (waddr1),
        .wdata1_i (lane_rec[1]),
        .raddr_i  (rd_ptr_q),
        .rdata_o  (head_rec)
    );

    assign bus_io.rec_valid = rec_valid;
    assign bus_io.rec       = rec_valid ? head_rec : '0;
    assign level_o          = level_q;
    assign overflow_o       = overflow_q;
    assign drop_cnt_o       = cnt_q;

`ifdef RETIRE_TRACE_SEQ_EN
    // Advances for dropped records too, so consumers see gaps where data was lost.
    logic [31:0] seq_q;
    logic [31:0] seq_mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_q + 32'(n);
        end
    end

    always_ff @(posedge clk_i) begin
        if (we0) begin
            seq_mem_q[wr_ptr_q] <= seq_q;
        end
        if (we1) begin
            seq_mem_q[waddr1] <= seq_q + 32'(bus_io.update[0]);
        end
    end

    assign rec_seq_o = rec_valid ? seq_mem_q[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_retire_trace_fifo.sv
module tb_retire_trace_fifo;
    import riscv_pkg::*;

    localparam int unsigned Depth    = 16;
    localparam int unsigned CntWidth = 16;

    logic                  clk;
    logic                  rstn;
    logic                  clear;
    logic [$clog2(Depth):0] level;
    logic                  overflow;
    logic [CntWidth-1:0]   drop_cnt;
`ifdef RETIRE_TRACE_SEQ_EN
    logic [31:0]           rec_seq;
`endif

    int checks = 0;
    int errors = 0;

    retire_trace_fifo_if #(.IssueWidth(2)) bus ();

    retire_trace_fifo #(
        .IssueWidth (2),
        .Depth      (Depth),
        .CntWidth   (CntWidth)
    ) u_dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .bus_io     (bus.slave),
        .level_o    (level),
        .overflow_o (overflow),
        .drop_cnt_o (drop_cnt),
        .clear_i    (clear)
`ifdef RETIRE_TRACE_SEQ_EN
        ,
        .rec_seq_o  (rec_seq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic dual(input logic [31:0] pc0, input logic [31:0] pc1);
        bus.update = 2'b11;
        bus.pc[0]  = pc0;
        bus.pc[1]  = pc1;
    endtask

    initial begin
        rstn          = 1'b0;
        clear         = 1'b0;
        bus.update    = '0;
        bus.pc        = '0;
        bus.instr     = '0;
        bus.reg_addr  = '0;
        bus.reg_data  = '0;
        bus.mem_addr  = '0;
        bus.mem_data  = '0;
        bus.mem_wrt   = '0;
        bus.rec_ready = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", 64'(bus.rec_valid), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_rec_zero", 64'(|bus.rec), 64'd0);
        rstn = 1'b1;

        // 1. Dual retire, lane 0 first
        dual(32'h0, 32'h4);
        bus.instr[1]  = 32'h00a0_0093;
        bus.rec_ready = 1'b1;
        step();
        bus.update = '0;
        chk("t1_valid", 64'(bus.rec_valid), 64'd1);
        chk("t1_pc0", 64'(bus.rec.pc), 64'h0);
        chk("t1_level2", 64'(level), 64'd2);
        step();
        chk("t1_pc1", 64'(bus.rec.pc), 64'h4);
        chk("t1_instr1", 64'(bus.rec.instr), 64'h00a0_0093);
        chk("t1_level1", 64'(level), 64'd1);
        step();
        chk("t1_empty", 64'(bus.rec_valid), 64'd0);
        chk("t1_rec_zero", 64'(|bus.rec), 64'd0);

        // 2. Lane 1 alone is compacted
        bus.update    = 2'b10;
        bus.pc[0]     = 32'hffff_fff0;
        bus.pc[1]     = 32'h10;
        bus.rec_ready = 1'b0;
        step();
        bus.update = '0;
        chk("t2_pc", 64'(bus.rec.pc), 64'h10);
        chk("t2_level", 64'(level), 64'd1);
        bus.rec_ready = 1'b1;
        step();
        chk("t2_drained", 64'(level), 64'd0);

        // 3. Fill to full, then atomic drop of a dual retire
        bus.rec_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dual(32'h200 + 32'(8 * i), 32'h204 + 32'(8 * i));
            step();
        end
        chk("t3_full", 64'(level), 64'd16);
        chk("t3_no_ovf", 64'(overflow), 64'd0);
        dual(32'h400, 32'h404);
        step();
        chk("t3_level", 64'(level), 64'd16);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_drop", 64'(drop_cnt), 64'd2);
        chk("t3_head", 64'(bus.rec.pc), 64'h200);

        // 4. Full + pop + single retire accepted; full + pop + dual dropped
        bus.rec_ready = 1'b1;
        bus.update    = 2'b01;
        bus.pc[0]     = 32'h300;
        step();
        chk("t4_level", 64'(level), 64'd16);
        chk("t4_drop", 64'(drop_cnt), 64'd2);
        chk("t4_head", 64'(bus.rec.pc), 64'h204);
        dual(32'h500, 32'h504);
        step();
        chk("t4b_level", 64'(level), 64'd15);
        chk("t4b_drop", 64'(drop_cnt), 64'd4);
        chk("t4b_head", 64'(bus.rec.pc), 64'h208);
        bus.update = '0;
        for (int i = 0; i < 15; i++) step();
        chk("t4_drained", 64'(level), 64'd0);

        // Walk write pointer from 4 to 15
        bus.update = 2'b01;
        for (int i = 0; i < 11; i++) begin
            bus.pc[0] = 32'h600 + 32'(4 * i);
            step();
        end
        bus.update = '0;
        step();
        chk("t5_pre_level", 64'(level), 64'd0);

        // 5. Dual retire straddling the wrap (slots 15, 0)
        bus.rec_ready = 1'b0;
        dual(32'h100, 32'h104);
        step();
        bus.update = '0;
        chk("t5_level", 64'(level), 64'd2);
        chk("t5_head0", 64'(bus.rec.pc), 64'h100);
        bus.rec_ready = 1'b1;
        step();
        chk("t5_head1", 64'(bus.rec.pc), 64'h104);
        step();
        chk("t5_empty", 64'(bus.rec_valid), 64'd0);

        // Clear coinciding with a drop, then a plain clear
        bus.rec_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dual(32'h700 + 32'(8 * i), 32'h704 + 32'(8 * i));
            step();
        end
        clear = 1'b1;
        dual(32'h800, 32'h804);
        step();
        chk("clr_drop_cnt", 64'(drop_cnt), 64'd2);
        chk("clr_drop_ovf", 64'(overflow), 64'd1);
        bus.update = '0;
        step();
        clear = 1'b0;
        chk("clr_cnt", 64'(drop_cnt), 64'd0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_keeps_data", 64'(level), 64'd16);
        chk("clr_head", 64'(bus.rec.pc), 64'h700);

        // 6. Mid-stream reset with level 5 and in-flight retires
        dual(32'h900, 32'h904);
        step();
        bus.update = '0;
        chk("t6_ovf_set", 64'(overflow), 64'd1);
        bus.rec_ready = 1'b1;
        for (int i = 0; i < 11; i++) step();
        chk("t6_level5", 64'(level), 64'd5);
        rstn = 1'b0;
        dual(32'ha00, 32'ha04);
        step();
        chk("t6_valid", 64'(bus.rec_valid), 64'd0);
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_ovf", 64'(overflow), 64'd0);
        chk("t6_drop", 64'(drop_cnt), 64'd0);
        chk("t6_rec_zero", 64'(|bus.rec), 64'd0);
        rstn       = 1'b1;
        bus.update = '0;
        step();
        chk("t6_discarded", 64'(level), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
